// File: rtl/multi_clock_enable_generator_pkg.sv
// ----------------------------------------------------------------------------
// multi_clock_enable_generator_pkg
//  Shared definitions for the clock-enable generator and its channel slices.
//  - ch_sel_w(): width of a channel-select field for a given channel count.
//  - Default divider constants for a 100 MHz system clock.
// ----------------------------------------------------------------------------
package multi_clock_enable_generator_pkg;

    // System clock the default dividers are computed for.
    localparam int unsigned MCEG_CLK_HZ   = 100_000_000;

    // 1 kHz tick: scan / debounce timebase (fits in 17 bits).
    localparam int unsigned MCEG_DIV_1KHZ = MCEG_CLK_HZ / 1_000;

    // 1 Hz tick: LED blink (needs 27 bits).
    localparam int unsigned MCEG_DIV_1HZ  = MCEG_CLK_HZ;

    // Channel-select width. A single channel still gets a 1-bit select so the
    // write port never collapses to zero width.
    function automatic int ch_sel_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/multi_clock_enable_generator_channel.sv
// ----------------------------------------------------------------------------
// multi_clock_enable_generator_channel (mceg_channel)
//  One clock-enable channel: up-counter, active divider, shadow divider,
//  registered CE strobe and pending flag.
//
//  Ports
//   I_CLK     in  1        clock
//   I_RST     in  1        synchronous active-high reset
//   I_EN      in  1        run enable; low clears the counter
//   I_SYNC    in  1        restart counter and apply shadow
//   I_LD      in  1        load I_LD_DIV into the shadow divider
//   I_LD_DIV  in  P_WIDTH  divider value for the load
//   O_CE      out 1        single-cycle strobe, one cycle after count N-1
//   O_PEND    out 1        shadow differs in time from active (not yet applied)
// ----------------------------------------------------------------------------
module mceg_channel
    import multi_clock_enable_generator_pkg::*;
#(
    parameter int                 P_WIDTH    = 17,
    parameter logic [P_WIDTH-1:0] P_DIV_INIT = P_WIDTH'(MCEG_DIV_1KHZ)
) (
    input  logic               I_CLK,
    input  logic               I_RST,
    input  logic               I_EN,
    input  logic               I_SYNC,
    input  logic               I_LD,
    input  logic [P_WIDTH-1:0] I_LD_DIV,
    output logic               O_CE,
    output logic               O_PEND
);

    logic [P_WIDTH-1:0] cnt_q, cnt_d;
    logic [P_WIDTH-1:0] act_q, act_d;
    logic [P_WIDTH-1:0] shd_q, shd_d;
    logic               ce_q,  ce_d;
    logic               pend_q, pend_d;

    // Shadow / pending as seen this cycle, with a same-cycle load folded in,
    // so a write coinciding with a wrap or sync is applied immediately.
    logic [P_WIDTH-1:0] shd_eff;
    logic               pend_eff;

    // idle: channel is not counting this cycle (sync, disabled, or N=0).
    logic               idle;
    logic               wrap;
    logic               apply;

    always_comb begin
        shd_eff  = I_LD ? I_LD_DIV : shd_q;
        pend_eff = pend_q | I_LD;

        idle  = I_SYNC | ~I_EN | (act_q == '0);
        // act_q is nonzero whenever idle is low, so act_q-1 cannot underflow.
        wrap  = ~idle & (cnt_q == (act_q - P_WIDTH'(1)));
        apply = idle | wrap;

        cnt_d  = cnt_q;
        act_d  = act_q;
        shd_d  = shd_eff;
        ce_d   = 1'b0;
        pend_d = pend_eff;

        if (idle) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
            ce_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + P_WIDTH'(1);
        end

        if (apply) begin
            act_d  = shd_eff;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            cnt_q  <= '0;
            act_q  <= P_DIV_INIT;
            shd_q  <= P_DIV_INIT;
            ce_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            ce_q   <= ce_d;
            pend_q <= pend_d;
        end
    end

    assign O_CE   = ce_q;
    assign O_PEND = pend_q;

endmodule

// File: rtl/multi_clock_enable_generator.sv
// ----------------------------------------------------------------------------
// multi_clock_enable_generator
//  P_CH independent single-cycle clock-enable strobes derived from I_CLK,
//  each with a run-time programmable divider. New dividers are staged in a
//  shadow register and take effect at the next wrap (or on disable, N=0, or
//  I_SYNC), so a running channel never produces a short or long period.
//
//  Ports
//   I_CLK       in  1        clock
//   I_RST       in  1        synchronous active-high reset
//   I_EN        in  P_CH     per-channel run enable
//   I_SYNC      in  1        restart all channels phase-aligned
//   I_WR        in  1        divider write strobe
//   I_WR_CH     in  P_CH_W   channel addressed by the write (>= P_CH ignored)
//   I_WR_DIV    in  P_WIDTH  new divider value
//   O_CE        out P_CH     registered CE strobes
//   O_DIV_PEND  out P_CH     written divider not yet active
// ----------------------------------------------------------------------------
module multi_clock_enable_generator
    import multi_clock_enable_generator_pkg::*;
#(
    parameter int                 P_CH       = 4,
    parameter int                 P_WIDTH    = 17,
    parameter logic [P_WIDTH-1:0] P_DIV_INIT = P_WIDTH'(MCEG_DIV_1KHZ),
    localparam int                P_CH_W     = ch_sel_w(P_CH)
) (
    input  logic               I_CLK,
    input  logic               I_RST,
    input  logic [P_CH-1:0]    I_EN,
    input  logic               I_SYNC,
    input  logic               I_WR,
    input  logic [P_CH_W-1:0]  I_WR_CH,
    input  logic [P_WIDTH-1:0] I_WR_DIV,
    output logic [P_CH-1:0]    O_CE,
    output logic [P_CH-1:0]    O_DIV_PEND
);

    // Per-channel load strobes. An out-of-range select matches no channel,
    // which is how writes to I_WR_CH >= P_CH get dropped.
    logic [P_CH-1:0] ld;

    always_comb begin
        ld = '0;
        for (int c = 0; c < P_CH; c++) begin
            ld[c] = I_WR & (I_WR_CH == P_CH_W'(c));
        end
    end

    for (genvar c = 0; c < P_CH; c++) begin : g_ch
        mceg_channel #(
            .P_WIDTH    (P_WIDTH),
            .P_DIV_INIT (P_DIV_INIT)
        ) u_ch (
            .I_CLK    (I_CLK),
            .I_RST    (I_RST),
            .I_EN     (I_EN[c]),
            .I_SYNC   (I_SYNC),
            .I_LD     (ld[c]),
            .I_LD_DIV (I_WR_DIV),
            .O_CE     (O_CE[c]),
            .O_PEND   (O_DIV_PEND[c])
        );
    end

endmodule

// File: tb/tb_multi_clock_enable_generator.sv
module tb_multi_clock_enable_generator;

    // Five channels with a 3-bit select so selects 5..7 exercise dropped writes.
    localparam int NCH  = 5;
    localparam int W    = 8;
    localparam int INIT = 5;

    logic           clk = 1'b0;
    logic           rst, sync, wr;
    logic [NCH-1:0] en;
    logic [2:0]     wr_ch;
    logic [W-1:0]   wr_div;
    logic [NCH-1:0] ce, pend;

    always #5 clk = ~clk;

    multi_clock_enable_generator #(
        .P_CH       (NCH),
        .P_WIDTH    (W),
        .P_DIV_INIT (W'(INIT))
    ) dut (
        .I_CLK      (clk),
        .I_RST      (rst),
        .I_EN       (en),
        .I_SYNC     (sync),
        .I_WR       (wr),
        .I_WR_CH    (wr_ch),
        .I_WR_DIV   (wr_div),
        .O_CE       (ce),
        .O_DIV_PEND (pend)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: per channel, cycles left until the next strobe,
    // counted down from the active divider after every restart or wrap.
    int             m_act  [NCH];
    int             m_shd  [NCH];
    int             m_left [NCH];
    logic [NCH-1:0] m_ce   = '0;
    logic [NCH-1:0] m_pend = '0;

    task automatic model_tick();
        for (int c = 0; c < NCH; c++) begin
            bit hit;
            int sn;
            hit = wr && (int'(wr_ch) == c);
            sn  = hit ? int'(wr_div) : m_shd[c];
            if (rst) begin
                m_act[c] = INIT; m_shd[c] = INIT; m_left[c] = INIT;
                m_ce[c] = 1'b0;  m_pend[c] = 1'b0;
            end else if (sync || !en[c] || m_act[c] == 0) begin
                m_act[c] = sn; m_shd[c] = sn; m_left[c] = sn;
                m_ce[c] = 1'b0; m_pend[c] = 1'b0;
            end else begin
                m_shd[c]  = sn;
                m_left[c] = m_left[c] - 1;
                if (m_left[c] == 0) begin
                    m_ce[c] = 1'b1; m_act[c] = sn; m_left[c] = sn; m_pend[c] = 1'b0;
                end else begin
                    m_ce[c] = 1'b0; m_pend[c] = m_pend[c] | hit;
                end
            end
        end
    endtask

    task automatic check_model();
        total++;
        assert (ce === m_ce) else begin
            bad++;
            $error("FAIL ce cyc=%0d got=%b exp=%b", cyc, ce, m_ce);
        end
        total++;
        assert (pend === m_pend) else begin
            bad++;
            $error("FAIL pend cyc=%0d got=%b exp=%b", cyc, pend, m_pend);
        end
    endtask

    // Directed constant check, independent of the model.
    task automatic check_const(input string tag, input logic [NCH-1:0] got,
                               input logic [NCH-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [NCH-1:0] e, input logic s,
                        input logic w, input logic [2:0] ch, input int d);
        rst = r; en = e; sync = s; wr = w; wr_ch = ch; wr_div = W'(d);
        @(posedge clk);
        model_tick();
        #1;
        cyc++;
        check_model();
    endtask

    task automatic run(input int n, input logic [NCH-1:0] e);
        repeat (n) step(1'b0, e, 1'b0, 1'b0, 3'd0, 0);
    endtask

    localparam logic [NCH-1:0] ALL = '1;

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_act[c] = INIT; m_shd[c] = INIT; m_left[c] = INIT;
        end

        // Reset and release, all enabled: strobes at 5, 10, 15.
        step(1'b1, ALL, 1'b0, 1'b0, 3'd0, 0);
        step(1'b1, ALL, 1'b0, 1'b0, 3'd0, 0);
        check_const("rst_ce", ce, '0);
        check_const("rst_pend", pend, '0);
        for (int k = 1; k <= 16; k++) begin
            run(1, ALL);
            check_const("t1_ce", ce, (k % 5 == 0) ? ALL : '0);
        end

        // Ch1 (div 5, counter now 1): one more cycle then write div 3 at counter 2.
        run(1, ALL);
        step(1'b0, ALL, 1'b0, 1'b1, 3'd1, 3);
        check_const("t2_pend", pend, 5'b00010);
        run(2, ALL);
        check_const("t2_oldwrap", ce, ALL);
        check_const("t2_pendclr", pend, '0);
        run(12, ALL);

        // Div 1 on ch0: constant high; then div 0: off.
        step(1'b0, ALL, 1'b0, 1'b1, 3'd0, 1);
        run(8, ALL);
        check_const("t3_div1", ce & 5'b00001, 5'b00001);
        step(1'b0, ALL, 1'b0, 1'b1, 3'd0, 0);
        run(2, ALL);
        for (int k = 0; k < 6; k++) begin
            run(1, ALL);
            check_const("t3_div0", ce & 5'b00001, '0);
        end

        // Ch0 and ch2 to div 4 at different times, then sync.
        step(1'b0, ALL, 1'b0, 1'b1, 3'd0, 4);
        run(3, ALL);
        step(1'b0, ALL, 1'b0, 1'b1, 3'd2, 4);
        run(7, ALL);
        step(1'b0, ALL, 1'b1, 1'b0, 3'd0, 0);
        check_const("t4_sync", ce, '0);
        for (int k = 1; k <= 12; k++) begin
            run(1, ALL);
            check_const("t4_aligned", ce & 5'b00101, (k % 4 == 0) ? 5'b00101 : '0);
        end

        // Drop en[3] for two cycles mid-count, then out-of-range writes.
        run(2, ALL);
        run(2, 5'b10111);
        for (int k = 1; k <= 10; k++) begin
            run(1, ALL);
            check_const("t5_reen", ce & 5'b01000, (k % 5 == 0) ? 5'b01000 : '0);
        end
        step(1'b0, ALL, 1'b0, 1'b1, 3'd5, 2);
        step(1'b0, ALL, 1'b0, 1'b1, 3'd7, 1);
        check_const("t5_oor", pend, '0);
        run(10, ALL);

        // Reset with writes pending.
        step(1'b0, ALL, 1'b0, 1'b1, 3'd1, 7);
        step(1'b0, ALL, 1'b0, 1'b1, 3'd4, 2);
        step(1'b1, ALL, 1'b0, 1'b0, 3'd0, 0);
        check_const("t6_ce", ce, '0);
        check_const("t6_pend", pend, '0);
        for (int k = 1; k <= 10; k++) begin
            run(1, ALL);
            check_const("t6_init", ce, (k % 5 == 0) ? ALL : '0);
        end

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            logic [NCH-1:0] e;
            e = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : ALL;
            step(($urandom_range(0, 499) == 0), e, ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
